// File: rtl/crc4_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : crc4_frame_tx
// Purpose  : Serial CRC-4 frame transmitter. Accepts a parallel message word
//            over a valid/ready handshake, shifts it out MSB first, and then
//            appends the 4-bit CRC (MSB first). A serial CRC-4 detector fed
//            with the resulting stream ends each frame with a residue of zero.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MSG_W   message width in bits (1..32)
//   POLY    generator low terms, x^4 implicit (default x^4 + x + 1)
//   INIT    CRC register value loaded at frame start
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   msg_in       in   MSG_W  message word, sampled on handshake
//   msg_valid    in   1      message word offered
//   msg_ready    out  1      block can accept a message word
//   data_out     out  1      serial frame bit, MSB first
//   data_valid   out  1      data_out carries a frame bit this cycle
//   frame_start  out  1      first message bit of a frame
//   frame_last   out  1      last CRC bit of a frame
//   crc_out      out  4      CRC of the last completed frame
// ============================================================================
module crc4_frame_tx #(
    parameter int unsigned MSG_W = 7,
    parameter logic [3:0]  POLY  = 4'b0011,
    parameter logic [3:0]  INIT  = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic [3:0]       crc_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The bit counter is shared by the message phase (1..MSG_W) and the CRC
    // phase (1..4), so it must be wide enough for the larger of the two.
    localparam int unsigned c_CNT_MAX = (MSG_W > 4) ? MSG_W : 4;
    localparam int unsigned c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_MSG_LAST  = c_CNT_W'(MSG_W);
    localparam logic [c_CNT_W-1:0] c_CRC_PENUL = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0] c_CRC_LAST  = c_CNT_W'(4);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_SHIFT_MSG = 2'd1;
    localparam logic [1:0] c_ST_SHIFT_CRC = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,       state_d;
    logic [MSG_W-1:0]   shreg_q,       shreg_d;
    logic [c_CNT_W-1:0] cnt_q,         cnt_d;
    logic [3:0]         crc_q,         crc_d;
    logic               data_out_q,    data_out_d;
    logic               data_valid_q,  data_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_last_q,  frame_last_d;
    logic [3:0]         crc_out_q,     crc_out_d;

    logic               w_accept;
    logic               w_fb;
    logic [3:0]         w_crc_step;
    logic [MSG_W-1:0]   w_sh_next;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    // Ready is gated by reset so a word offered during reset is never taken.
    assign msg_ready = (state_q == c_ST_IDLE) && !reset;
    assign w_accept  = msg_valid && msg_ready;

    // During the message phase data_out_q is exactly the bit on the line this
    // cycle, so it is the bit folded into the CRC at the next edge.
    assign w_fb       = crc_q[3] ^ data_out_q;
    assign w_crc_step = {crc_q[2:0], 1'b0} ^ (w_fb ? POLY : 4'b0000);

    // Shifting the whole register keeps the indexing legal for MSG_W = 1.
    assign w_sh_next  = shreg_q << 1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        frame_start_d = 1'b0;
        frame_last_d  = 1'b0;
        crc_out_d     = crc_out_q;

        case (state_q)
            c_ST_IDLE: begin
                data_out_d   = 1'b0;
                data_valid_d = 1'b0;
                if (w_accept) begin
                    state_d       = c_ST_SHIFT_MSG;
                    shreg_d       = msg_in;
                    cnt_d         = c_CNT_ONE;
                    crc_d         = INIT;
                    data_out_d    = msg_in[MSG_W-1];
                    data_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end

            c_ST_SHIFT_MSG: begin
                // cnt_q counts message bits already placed on the line.
                crc_d = w_crc_step;
                if (cnt_q == c_MSG_LAST) begin
                    // Last message bit absorbed: the updated CRC is final and
                    // its MSB goes out immediately so there is no gap.
                    state_d    = c_ST_SHIFT_CRC;
                    cnt_d      = c_CNT_ONE;
                    crc_out_d  = w_crc_step;
                    data_out_d = w_crc_step[3];
                end else begin
                    shreg_d    = w_sh_next;
                    cnt_d      = cnt_q + c_CNT_ONE;
                    data_out_d = w_sh_next[MSG_W-1];
                end
            end

            c_ST_SHIFT_CRC: begin
                // crc_q[3] is on the line; the next bit to present is crc_q[2].
                if (cnt_q == c_CRC_LAST) begin
                    state_d      = c_ST_IDLE;
                    data_out_d   = 1'b0;
                    data_valid_d = 1'b0;
                end else begin
                    cnt_d        = cnt_q + c_CNT_ONE;
                    crc_d        = {crc_q[2:0], 1'b0};
                    data_out_d   = crc_q[2];
                    frame_last_d = (cnt_q == c_CRC_PENUL);
                end
            end

            default: begin
                state_d      = c_ST_IDLE;
                data_out_d   = 1'b0;
                data_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= c_ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            crc_q         <= 4'b0000;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            crc_out_q     <= 4'b0000;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            crc_out_q     <= crc_out_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign crc_out     = crc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_crc4_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc4_frame_tx
// Purpose  : Self-checking bench for crc4_frame_tx. Three instances cover
//            MSG_W = 7, 8 and 1. Accepted words push an expected codeword to
//            a scoreboard; a monitor rebuilds each frame from the serial
//            stream and compares it when data_valid falls.
// Revision : 1.0  initial release
// ============================================================================
module tb_crc4_frame_tx;

    typedef struct {
        int          inst;
        int          len;
        logic [35:0] cw;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0][31:0] msg;
    logic [2:0]       vld;
    logic [2:0]       rdy;
    logic [2:0]       dout;
    logic [2:0]       dv;
    logic [2:0]       fs;
    logic [2:0]       fl;
    logic [2:0][3:0]  co;

    crc4_frame_tx #(.MSG_W(7)) u_dut7 (
        .clk(clk), .reset(reset), .msg_in(msg[0][6:0]), .msg_valid(vld[0]),
        .msg_ready(rdy[0]), .data_out(dout[0]), .data_valid(dv[0]),
        .frame_start(fs[0]), .frame_last(fl[0]), .crc_out(co[0])
    );

    crc4_frame_tx #(.MSG_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .msg_in(msg[1][7:0]), .msg_valid(vld[1]),
        .msg_ready(rdy[1]), .data_out(dout[1]), .data_valid(dv[1]),
        .frame_start(fs[1]), .frame_last(fl[1]), .crc_out(co[1])
    );

    crc4_frame_tx #(.MSG_W(1)) u_dut1 (
        .clk(clk), .reset(reset), .msg_in(msg[2][0:0]), .msg_valid(vld[2]),
        .msg_ready(rdy[2]), .data_out(dout[2]), .data_valid(dv[2]),
        .frame_start(fs[2]), .frame_last(fl[2]), .crc_out(co[2])
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   acc[3];
    int   nframes[3];

    logic [35:0] m_bits[3];
    logic [35:0] m_last_bits[3];
    int          m_len[3];
    int          m_nfs[3];
    int          m_nfl[3];
    int          m_idle[3];
    logic        m_in[3];
    logic        m_firstfs[3];
    logic        m_lastfl[3];
    logic        m_gap_armed[3];
    logic        hold[3];

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int k);
        case (k)
            0:       return 7;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference CRC by polynomial long division of msg * x^4 by x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [35:0] m, input int w);
        logic [35:0] r;
        r = m << 4;
        for (int i = w + 3; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    // Downstream serial detector: residue over a full codeword.
    function automatic logic [3:0] detect(input logic [35:0] bits, input int len);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = len - 1; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic exp_t make_exp(input int k, input logic [31:0] m);
        exp_t        e;
        int          w;
        logic [35:0] mm;
        w      = w_of(k);
        mm     = 36'(m) & ((36'd1 << w) - 36'd1);
        e.inst = k;
        e.len  = w + 4;
        e.cw   = (mm << 4) | 36'(crc_ref(mm, w));
        return e;
    endfunction

    task automatic drop_exp(input int k);
        int idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].inst == k) idx = i;
        if (idx >= 0) exp_q.delete(idx);
    endtask

    task automatic close_frame(input int k);
        exp_t e;
        int   idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].inst == k) idx = i;
        nframes[k]++;
        m_last_bits[k] = m_bits[k];
        if (idx < 0) begin
            check("unexpected_frame", 36'd1, 36'd0);
            return;
        end
        e = exp_q[idx];
        exp_q.delete(idx);
        check("frame_len",     36'(m_len[k]),       36'(e.len));
        check("stream",        m_bits[k],           e.cw);
        check("crc_out",       36'(co[k]),          36'(e.cw[3:0]));
        check("start_count",   36'(m_nfs[k]),       36'd1);
        check("start_first",   36'(m_firstfs[k]),   36'd1);
        check("last_count",    36'(m_nfl[k]),       36'd1);
        check("last_on_final", 36'(m_lastfl[k]),    36'd1);
        check("residue",       36'(detect(m_bits[k], m_len[k])), 36'd0);
    endtask

    // Acceptance: push the expected codeword when a word is taken.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld[k] === 1'b1 && rdy[k] === 1'b1) begin
                exp_q.push_back(make_exp(k, msg[k]));
                acc[k]++;
            end
        end
    end

    // Monitor: rebuild frames from the serial stream.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset === 1'b1) begin
                if (m_in[k]) begin
                    drop_exp(k);
                    m_in[k] = 1'b0;
                end
                m_gap_armed[k] = 1'b0;
                m_idle[k]      = 0;
            end else if (dv[k] === 1'b1) begin
                if (!m_in[k]) begin
                    if (m_gap_armed[k]) check("idle_gap", 36'(m_idle[k]), 36'd1);
                    m_gap_armed[k] = 1'b0;
                    m_in[k]        = 1'b1;
                    m_bits[k]      = '0;
                    m_len[k]       = 0;
                    m_nfs[k]       = 0;
                    m_nfl[k]       = 0;
                    m_firstfs[k]   = fs[k];
                end
                m_bits[k]   = {m_bits[k][34:0], dout[k]};
                m_len[k]++;
                m_nfs[k]   += int'(fs[k]);
                m_nfl[k]   += int'(fl[k]);
                m_lastfl[k] = fl[k];
            end else begin
                if (m_in[k]) begin
                    close_frame(k);
                    m_in[k]        = 1'b0;
                    m_idle[k]      = 1;
                    m_gap_armed[k] = hold[k];
                end else begin
                    m_idle[k]++;
                end
            end
        end
    end

    task automatic send(input int k, input logic [31:0] m);
        int a0, f0, n;
        a0     = acc[k];
        f0     = nframes[k];
        msg[k] = m;
        vld[k] = 1'b1;
        n = 0;
        while (acc[k] == a0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        vld[k] = 1'b0;
        check("accept", 36'(acc[k] - a0), 36'd1);
        n = 0;
        while (nframes[k] == f0 && n < 100) begin
            @(negedge clk);
            msg[k] = $urandom;
            n++;
        end
        check("frame_done", 36'(nframes[k] - f0), 36'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, f0, n;
        reset = 1'b1;
        vld   = '0;
        msg   = '0;
        for (int k = 0; k < 3; k++) begin
            m_in[k] = 1'b0; m_gap_armed[k] = 1'b0; hold[k] = 1'b0; m_idle[k] = 0;
            m_bits[k] = '0; m_last_bits[k] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdy_in_reset", 36'(rdy[0]), 36'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_data_valid",  36'(dv[0]),   36'd0);
        check("rst_data_out",    36'(dout[0]), 36'd0);
        check("rst_frame_start", 36'(fs[0]),   36'd0);
        check("rst_frame_last",  36'(fl[0]),   36'd0);
        check("rst_crc_out",     36'(co[0]),   36'd0);
        check("rdy_after_reset", 36'(rdy[0]),  36'd1);

        // Known CRC values for MSG_W = 7
        send(0, 32'b1000000);
        check("crc_1000000", 36'(co[0]), 36'b0111);
        send(0, 32'b0000001);
        check("crc_0000001", 36'(co[0]), 36'b0011);
        send(0, 32'b0000000);
        check("crc_zero", 36'(co[0]), 36'b0000);
        send(0, 32'b1011001);
        check("crc_1011001", 36'(co[0]), 36'b1010);
        check("stream_1011001", m_last_bits[0], 36'b1011001_1010);

        // Back-to-back frames with msg_valid held and msg_in churning
        hold[0] = 1'b1;
        a0 = acc[0];
        f0 = nframes[0];
        vld[0] = 1'b1;
        n = 0;
        while (acc[0] < a0 + 3 && n < 200) begin
            msg[0] = $urandom;
            @(posedge clk); #1; n++;
        end
        vld[0] = 1'b0;
        check("hold_accepts", 36'(acc[0] - a0), 36'd3);
        n = 0;
        while (nframes[0] < f0 + 3 && n < 200) begin
            @(negedge clk); n++;
        end
        check("hold_frames", 36'(nframes[0] - f0), 36'd3);
        @(negedge clk);
        hold[0] = 1'b0;
        m_gap_armed[0] = 1'b0;

        // Reset on the 5th bit of a frame, with msg_valid high during reset
        send(0, 32'b1011001);
        a0 = acc[0];
        f0 = nframes[0];
        msg[0] = 32'b1011001;
        vld[0] = 1'b1;
        n = 0;
        while (acc[0] == a0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        vld[0] = 1'b0;
        check("abort_accept", 36'(acc[0] - a0), 36'd1);
        repeat (4) @(posedge clk);
        #1;
        reset  = 1'b1;
        vld[0] = 1'b1;
        @(negedge clk);
        check("abort_bit5_valid", 36'(dv[0]),  36'd1);
        check("rdy_in_reset2",    36'(rdy[0]), 36'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid",       36'(dv[0]),  36'd0);
        check("abort_crc_out",     36'(co[0]),  36'd0);
        check("abort_last",        36'(fl[0]),  36'd0);
        check("rdy_after_release", 36'(rdy[0]), 36'd1);
        check("abort_no_frame",    36'(nframes[0] - f0), 36'd0);
        a0 = acc[0];
        n = 0;
        while (acc[0] == a0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        vld[0] = 1'b0;
        check("post_reset_accept", 36'(acc[0] - a0), 36'd1);
        n = 0;
        while (nframes[0] == f0 && n < 100) begin
            @(negedge clk); n++;
        end
        check("post_reset_frame",  36'(nframes[0] - f0), 36'd1);
        check("post_reset_crc",    36'(co[0]), 36'b1010);
        check("post_reset_stream", m_last_bits[0], 36'b1011001_1010);

        // MSG_W = 8
        send(1, 32'h0000_00FF);
        check("stream_ff", m_last_bits[1], {24'd0, 8'hFF, crc_ref(36'hFF, 8)});
        send(1, 32'h0000_005A);
        send(1, $urandom);

        // MSG_W = 1
        send(2, 32'd1);
        check("crc_w1_one", 36'(co[2]), 36'b0011);
        send(2, 32'd0);
        check("crc_w1_zero", 36'(co[2]), 36'b0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 36'(exp_q.size()), 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
